arb_req_frontend: RTL and testbench
===================================

Name: arb_req_frontend

Overview:
- Upstream front end for the 2-way registered arbiter.
- Holds two small per-requester FIFOs and drives the arbiter's request[1:0] from their occupancy.
- Pops the head entry of whichever FIFO the arbiter's grant[1:0] selects, and forwards that entry to a shared output as a one-cycle strobe tagged with its source.
- Ensures the arbiter never sees a request that has no data behind it.

Parameters:
- DATA_W, 8: payload width per entry.
- DEPTH, 4: entries per FIFO. Power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 offers an entry.
- in0_ready  output  1  FIFO 0 accepts an entry this cycle.
- in0_data  input  DATA_W  requester 0 payload.
- in1_valid  input  1  requester 1 offers an entry.
- in1_ready  output  1  FIFO 1 accepts an entry this cycle.
- in1_data  input  DATA_W  requester 1 payload.
- request  output  2  to arbiter request[1:0]; bit i belongs to FIFO i.
- grant  input  2  from arbiter grant[1:0]; registered by the arbiter, one cycle after request.
- out_valid  output  1  forwarded-entry strobe.
- out_src  output  1  source FIFO index of the forwarded entry.
- out_data  output  DATA_W  forwarded payload.
- grant_err  output  1  sticky illegal-grant flag.

Behaviour:
- Clocking and reset:
  - One clock domain (clk). reset is synchronous and active-high.
  - While reset is high, the following are cleared: both FIFOs (pointers and count_i = 0), out_valid = 0, out_src = 0, out_data = 0, grant_err = 0.
  - During reset, in0_ready = in1_ready = 0 and request = 2'b00.
  - Asserting reset mid-operation discards all queued entries; there is no drain.
- Push:
  - in_ready_i = (count_i < DEPTH), evaluated before any pop in the same cycle. This is deliberately conservative: a full FIFO stays not-ready even in a cycle where it pops.
  - A push occurs when in_valid_i && in_ready_i, at the write pointer.
  - Write pointers wrap modulo DEPTH.
- Request generation:
  - request[i] = (count_i > grant[i]), combinational from count_i and grant[i].
  - This withdraws the last entry's request in the same cycle it is granted, so the arbiter's next grant cannot target an empty FIFO.
  - There is no combinational loop, because the arbiter's grant is registered.
- Pop and forward:
  - Valid grant: grant == 2'b01 or 2'b10, and count_i > 0 for the granted FIFO i.
  - On a valid grant, the head of FIFO i pops at the clock edge. Registered outputs update at that edge: out_valid = 1, out_src = i, out_data = head_i.
  - Latency from grant high to the out_valid cycle is 1. The read pointer wraps modulo DEPTH.
  - With no valid grant, out_valid = 0 and out_data/out_src hold their previous values.
- Simultaneous push and pop on the same FIFO: both take effect and count_i is unchanged.
  - Push into an empty FIFO: the new entry is not poppable until the next cycle, because request reflects the pre-push count.
- Error handling:
  - Illegal grant: grant == 2'b11, or grant[i] with count_i == 0.
  - On an illegal grant there is no pop, out_valid = 0, and grant_err is set.
  - grant_err clears only on reset.
- Counts: count_i ranges 0..DEPTH, held in clog2(DEPTH)+1 bits.
  - Overflow is impossible because of in_ready.
  - Underflow is impossible because of the illegal-grant guard.
- Ordering: each FIFO is strict FIFO. Cross-FIFO ordering is whatever the arbiter's grant sequence produces.

Test Plan:
- Reset:
  - Hold reset 9 cycles with in0_valid = in1_valid = 1.
  - Require: in_ready = 0, request = 00, out_valid = 0, grant_err = 0 throughout.
  - Release reset; require in0_ready = in1_ready = 1 on the next cycle.
- Single requester:
  - Push 0xA1, 0xA2, 0xA3 into FIFO 0; the bench arbiter grants 01 one cycle after each request.
  - Require out_valid pulses with out_src = 0 and data A1, A2, A3 in order.
  - Require request[0] = 0 in the cycle grant[0] pops A3; no grant_err.
- Contention:
  - Fill FIFO 0 with 0x10–0x13 and FIFO 1 with 0x20–0x23; the arbiter alternates grants.
  - Require the output sequence 10, 20, 11, 21, 12, 22, 13, 23 (src 0,1,0,1,…).
  - Require request = 00 after the final pop.
- Full and wrap:
  - Push DEPTH = 4 entries into FIFO 1 with no grant; require in1_ready = 0.
  - Grant one entry and push one more in the same cycle; require in1_ready to stay 0 that cycle (conservative rule), then return to 1.
  - Continue for 3×DEPTH entries 0x00–0x0B; require correct order across pointer wrap.
- Illegal grant:
  - Drive grant = 11 with both FIFOs non-empty; require out_valid = 0, no count change, grant_err = 1 and held.
  - Separately drive grant = 10 with FIFO 1 empty; require the same response.
- Reset mid-stream:
  - Apply reset with 3 entries queued in FIFO 0.
  - After release, require request = 00 and no out_valid until new pushes occur.
  - Require the first output after the new push to be the newly pushed entry.

Source files
------------

// File: rtl/arb_req_frontend_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : arb_req_frontend_if
// Brief    : Requester, arbiter and forward-path signals of the frontend.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface arb_req_frontend_if #(
    parameter int DATA_W = 8
);
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] in1_data;
    logic [1:0]        request;
    logic [1:0]        grant;
    logic              out_valid;
    logic              out_src;
    logic [DATA_W-1:0] out_data;
    logic              grant_err;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, grant,
        output in0_ready, in1_ready, request, out_valid, out_src, out_data, grant_err
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, grant,
        input  in0_ready, in1_ready, request, out_valid, out_src, out_data, grant_err
    );
endinterface
`default_nettype wire

// File: rtl/arb_req_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : arb_req_frontend
// Brief    : Two per-requester FIFOs feeding a registered 2-way arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module arb_req_frontend #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    arb_req_frontend_if.slave bus
);
    localparam int                  c_ptr_w = $clog2(DEPTH);
    localparam int                  c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

    logic [1:0]                 w_in_valid;
    logic [1:0]                 w_in_ready;
    logic [1:0]                 w_push;
    logic [1:0]                 w_pop;
    logic [1:0]                 w_request;
    logic [1:0][DATA_W-1:0]     w_in_data;
    logic [1:0][DATA_W-1:0]     w_head;
    logic [1:0][c_cnt_w-1:0]    w_count;
    logic                       w_illegal;

    logic                       r_out_valid;
    logic                       r_out_src;
    logic [DATA_W-1:0]          r_out_data;
    logic                       r_grant_err;

    assign w_in_valid = {bus.in1_valid, bus.in0_valid};
    assign w_in_data  = {bus.in1_data, bus.in0_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0]  r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_wptr;
            logic [c_ptr_w-1:0] r_rptr;
            logic [c_cnt_w-1:0] r_count;

            assign w_count[gi]    = r_count;
            assign w_head[gi]     = r_mem[r_rptr];
            // Ready uses the pre-pop count, so a full FIFO refuses even while popping.
            assign w_in_ready[gi] = !reset && (r_count < c_depth);
            assign w_push[gi]     = w_in_valid[gi] && w_in_ready[gi];
            // Withdraw the last entry's request in the cycle it is being granted.
            assign w_request[gi]  = !reset && (r_count > c_cnt_w'(bus.grant[gi]));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[gi]) r_wptr <= r_wptr + c_ptr_one;
                    if (w_pop[gi])  r_rptr <= r_rptr + c_ptr_one;
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + c_cnt_one;
                        2'b01:   r_count <= r_count - c_cnt_one;
                        default: r_count <= r_count;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[gi]) r_mem[r_wptr] <= w_in_data[gi];
            end
        end
    endgenerate

    assign w_pop[0]  = (bus.grant == 2'b01) && (w_count[0] != '0);
    assign w_pop[1]  = (bus.grant == 2'b10) && (w_count[1] != '0);
    assign w_illegal = (bus.grant == 2'b11)
                     || (bus.grant[0] && (w_count[0] == '0))
                     || (bus.grant[1] && (w_count[1] == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_out_data  <= '0;
            r_grant_err <= 1'b0;
        end else begin
            r_out_valid <= |w_pop;
            if (w_pop[1]) begin
                r_out_src  <= 1'b1;
                r_out_data <= w_head[1];
            end else if (w_pop[0]) begin
                r_out_src  <= 1'b0;
                r_out_data <= w_head[0];
            end
            if (w_illegal) r_grant_err <= 1'b1;
        end
    end

    assign bus.in0_ready = w_in_ready[0];
    assign bus.in1_ready = w_in_ready[1];
    assign bus.request   = w_request;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign bus.out_data  = r_out_data;
    assign bus.grant_err = r_grant_err;
endmodule
`default_nettype wire

// File: tb/tb_arb_req_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_arb_req_frontend
// Brief    : Queue-model bench for arb_req_frontend with a bench-side arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_arb_req_frontend;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arb_req_frontend_if #(.DATA_W(DATA_W)) bus ();

    arb_req_frontend #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_valid, m_src, m_err;
    logic [7:0] m_data;
    logic [1:0] prev_req;
    logic       rr;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input logic rst, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic [1:0] g, input bit use_arb);
        logic [1:0] gg, req;
        logic r0, r1, pop0, pop1, ill;
        if (use_arb) begin
            case (prev_req)
                2'b01:   gg = 2'b01;
                2'b10:   gg = 2'b10;
                2'b11:   gg = rr ? 2'b10 : 2'b01;
                default: gg = 2'b00;
            endcase
            if (gg != 2'b00) rr = gg[0];
        end else begin
            gg = g;
        end
        @(negedge clk);
        reset = rst;
        bus.in0_valid = v0; bus.in0_data = d0;
        bus.in1_valid = v1; bus.in1_data = d1;
        bus.grant = gg;
        #1;
        r0 = !rst && (q0.size() < DEPTH);
        r1 = !rst && (q1.size() < DEPTH);
        req[0] = !rst && (q0.size() > int'(gg[0]));
        req[1] = !rst && (q1.size() > int'(gg[1]));
        check("in0_ready", 32'(bus.in0_ready), 32'(r0));
        check("in1_ready", 32'(bus.in1_ready), 32'(r1));
        check("request", 32'(bus.request), 32'(req));
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete();
            m_valid = 0; m_src = 0; m_data = '0; m_err = 0;
        end else begin
            ill  = (gg == 2'b11) || (gg[0] && q0.size() == 0) || (gg[1] && q1.size() == 0);
            pop0 = (gg == 2'b01) && (q0.size() > 0);
            pop1 = (gg == 2'b10) && (q1.size() > 0);
            m_valid = pop0 || pop1;
            if (pop0) begin m_src = 0; m_data = q0.pop_front(); end
            if (pop1) begin m_src = 1; m_data = q1.pop_front(); end
            if (ill) m_err = 1;
            if (v0 && r0) q0.push_back(d0);
            if (v1 && r1) q1.push_back(d1);
        end
        prev_req = req;
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_src", 32'(bus.out_src), 32'(m_src));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("grant_err", 32'(bus.grant_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 8'h00, 0, 8'h00, 2'b00, 1);
    endtask

    initial begin
        int nxt;
        int guard;
        logic [1:0] g;
        reset = 1'b1;
        bus.in0_valid = 0; bus.in0_data = '0;
        bus.in1_valid = 0; bus.in1_data = '0;
        bus.grant = 2'b00;
        prev_req = 2'b00; rr = 0;
        m_valid = 0; m_src = 0; m_data = '0; m_err = 0;

        // Reset held with both requesters offering
        repeat (9) step(1, 1, 8'hEE, 1, 8'hDD, 2'b00, 0);
        step(0, 0, 8'h00, 0, 8'h00, 2'b00, 0);

        // Single requester
        step(0, 1, 8'hA1, 0, 8'h00, 2'b00, 1);
        step(0, 1, 8'hA2, 0, 8'h00, 2'b00, 1);
        step(0, 1, 8'hA3, 0, 8'h00, 2'b00, 1);
        idle(6);

        // Contention with alternating grants
        rr = 0;
        for (int k = 0; k < 4; k++)
            step(0, 1, 8'(8'h10 + k), 1, 8'(8'h20 + k), 2'b00, 0);
        idle(12);

        // Full FIFO 1, conservative ready, wrap
        for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 1, 8'(k), 2'b00, 0);
        step(0, 0, 8'h00, 1, 8'h04, 2'b00, 0);
        step(0, 0, 8'h00, 1, 8'h04, 2'b10, 0);
        nxt = 4; guard = 0;
        while (nxt < 12 && guard < 200) begin
            logic pred;
            pred = (q1.size() < DEPTH);
            step(0, 0, 8'h00, 1, 8'(nxt), 2'b00, 1);
            if (pred) nxt++;
            guard++;
        end
        check("wrap_progress", 32'(nxt), 32'd12);
        idle(12);

        // Illegal grant 11 with both non-empty
        step(0, 1, 8'h41, 1, 8'h51, 2'b00, 0);
        step(0, 1, 8'h42, 1, 8'h52, 2'b00, 0);
        step(0, 0, 8'h00, 0, 8'h00, 2'b11, 0);
        step(0, 0, 8'h00, 0, 8'h00, 2'b00, 0);
        idle(6);
        step(1, 0, 8'h00, 0, 8'h00, 2'b00, 0);
        // Illegal grant 10 with FIFO 1 empty
        step(0, 1, 8'h61, 0, 8'h00, 2'b00, 0);
        step(0, 0, 8'h00, 0, 8'h00, 2'b10, 0);
        idle(4);
        step(1, 0, 8'h00, 0, 8'h00, 2'b00, 0);

        // Reset mid-stream
        for (int k = 0; k < 3; k++) step(0, 1, 8'(8'h31 + k), 0, 8'h00, 2'b00, 0);
        step(1, 0, 8'h00, 0, 8'h00, 2'b00, 0);
        idle(3);
        step(0, 1, 8'h55, 0, 8'h00, 2'b00, 1);
        idle(4);

        // Random traffic with a randomized legal arbiter and rare resets
        for (int c = 0; c < 600; c++) begin
            logic rs;
            rs = ($urandom_range(0, 99) == 0);
            if (prev_req == 2'b11) g = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            else g = prev_req;
            if ($urandom_range(0, 7) == 0) g = 2'b00;
            step(rs, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 8'($urandom), g, 0);
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
